// File: rtl/mac_requester.sv
// Sequential multiply-accumulate requester: issues one operand pair at a time
// to an external multiplier and saturating-accumulates the products per vector.
module mac_requester #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_a_i,
  input  logic [31:0] in_b_i,
  input  logic        in_last_i,
  input  logic        cfg_sign_i,
  input  logic        cfg_upper_i,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic        mul_enable_o,
  output logic        mul_sign_o,
  output logic        mul_up_or_low_o,
  input  logic [31:0] mul_product_i,
  input  logic        mul_ready_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_acc_o,
  output logic        out_sat_o,
  output logic        err_timeout_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACCUM,
    OUT
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   a_q;
  logic [31:0]   b_q;
  logic [31:0]   prod_q;
  logic [31:0]   acc_q;
  logic          last_q;
  logic          sign_q;
  logic          upper_q;
  logic          first_q;
  logic          sat_q;
  logic          err_q;
  logic [TW-1:0] timer_q;

  logic          accept;
  logic          mul_hit;
  logic          timeout;
  logic          out_fire;

  logic [32:0]   usum;
  logic [31:0]   ssum;
  logic          sovf;
  logic [31:0]   sum_val;
  logic          sum_clamp;

  assign in_ready_o = (state == IDLE) & ~reset;
  assign accept     = in_valid_i & in_ready_o;
  assign mul_hit    = (state == WAIT) & mul_ready_i;
  assign timeout    = (state == WAIT) & ~mul_ready_i
                    & (timer_q == T_LAST);
  assign out_fire   = (state == OUT) & out_ready_i;

  assign mul_a_o         = a_q;
  assign mul_b_o         = b_q;
  assign mul_sign_o      = sign_q;
  assign mul_up_or_low_o = upper_q;
  assign mul_enable_o    = (state == ISSUE) & ~reset;
  assign out_valid_o     = (state == OUT) & ~reset;
  assign out_acc_o       = out_valid_o ? acc_q : 32'h0;
  assign out_sat_o       = sat_q;
  assign err_timeout_o   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT: begin
        if (mul_hit) begin
          state_nxt = ACCUM;
        end else if (timeout) begin
          state_nxt = IDLE;
        end
      end
      ACCUM:   state_nxt = last_q ? OUT : IDLE;
      OUT:     if (out_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Signed overflow only when both addends share a sign the sum lost.
  always_comb begin
    usum      = {1'b0, acc_q} + {1'b0, prod_q};
    ssum      = acc_q + prod_q;
    sovf      = (acc_q[31] == prod_q[31])
              & (ssum[31] != acc_q[31]);
    sum_val   = usum[31:0];
    sum_clamp = 1'b0;
    if (sign_q) begin
      sum_clamp = sovf;
      if (sovf) begin
        sum_val = acc_q[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        sum_val = ssum;
      end
    end else begin
      sum_clamp = usum[32];
      if (usum[32]) begin
        sum_val = 32'hFFFF_FFFF;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      acc_q   <= '0;
      last_q  <= 1'b0;
      sign_q  <= 1'b0;
      upper_q <= 1'b0;
      first_q <= 1'b1;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      if (accept) begin
        a_q    <= in_a_i;
        b_q    <= in_b_i;
        last_q <= in_last_i;
        if (first_q) begin
          sign_q  <= cfg_sign_i;
          upper_q <= cfg_upper_i;
          first_q <= 1'b0;
        end
      end
      if (state == ISSUE) begin
        timer_q <= '0;
      end
      if ((state == WAIT) & ~mul_ready_i & ~timeout) begin
        timer_q <= timer_q + 1'b1;
      end
      if (mul_hit) begin
        prod_q <= mul_product_i;
      end
      if (timeout) begin
        err_q   <= 1'b1;
        acc_q   <= '0;
        sat_q   <= 1'b0;
        first_q <= 1'b1;
      end
      if (state == ACCUM) begin
        acc_q <= sum_val;
        if (sum_clamp) begin
          sat_q <= 1'b1;
        end
      end
      if (out_fire) begin
        acc_q   <= '0;
        sat_q   <= 1'b0;
        first_q <= 1'b1;
      end
    end
  end

endmodule
